vending_param: RTL



---
 rtl/vending_param.sv | 125 ++++++++++++
 1 files changed

// File: rtl/vending_param.sv
// Coin vending controller with configurable price and optional 25 coin.
// Change and refunds are returned as a serial stream of chg5 pulses.
module vending_param #(
  parameter int PRICE_UNITS = 4,
  parameter int CW          = 4,
  parameter bit COIN25_EN   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    coin,
  input  logic          cancel,
  output logic          dispense,
  output logic          chg5,
  output logic          coin_reject,
  output logic          ready,
  output logic [CW-1:0] credit
);

  typedef enum logic {IDLE, CHANGE} state_t;

  localparam logic [CW-1:0] PRICE = CW'(PRICE_UNITS);

  state_t        state_reg;
  logic [CW-1:0] credit_reg;
  logic [CW-1:0] cnt_reg;
  logic          dispense_reg;
  logic          chg5_reg;
  logic          reject_reg;

  logic          coin_valid;
  logic [CW-1:0] coin_units;
  logic [CW-1:0] sum;
  logic          take_refund;
  logic          take_sale;
  logic [CW-1:0] ret_units;

  always_comb begin
    coin_valid = 1'b0;
    coin_units = '0;
    case (coin)
      2'b01: begin
        coin_valid = 1'b1;
        coin_units = CW'(1);
      end
      2'b10: begin
        coin_valid = 1'b1;
        coin_units = CW'(2);
      end
      2'b11: begin
        coin_valid = COIN25_EN;
        coin_units = COIN25_EN ? CW'(5) : '0;
      end
      default: begin
        coin_valid = 1'b0;
        coin_units = '0;
      end
    endcase
  end

  // Invalid coins contribute nothing, so a refund of credit+coin is just sum.
  always_comb begin
    sum         = credit_reg + coin_units;
    take_refund = cancel && (sum != '0);
    take_sale   = !cancel && coin_valid && (sum >= PRICE);
    ret_units   = '0;
    if (take_refund) begin
      ret_units = sum;
    end else if (take_sale) begin
      ret_units = sum - PRICE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      credit_reg   <= '0;
      cnt_reg      <= '0;
      dispense_reg <= 1'b0;
      chg5_reg     <= 1'b0;
      reject_reg   <= 1'b0;
    end else begin
      dispense_reg <= 1'b0;
      chg5_reg     <= 1'b0;
      reject_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          reject_reg <= (coin != 2'b00) && !coin_valid;
          if (take_refund || take_sale) begin
            credit_reg   <= '0;
            dispense_reg <= take_sale;
            chg5_reg     <= (ret_units != '0);
            // cnt_reg counts the chg5 cycles still owed after the next one
            if (ret_units > CW'(1)) begin
              state_reg <= CHANGE;
              cnt_reg   <= ret_units - CW'(1);
            end
          end else if (!cancel && coin_valid) begin
            credit_reg <= sum;
          end
        end
        CHANGE: begin
          chg5_reg   <= 1'b1;
          reject_reg <= (coin != 2'b00);
          if (cnt_reg <= CW'(1)) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign dispense    = dispense_reg;
  assign chg5        = chg5_reg;
  assign coin_reject = reject_reg;
  assign credit      = credit_reg;
  assign ready       = (state_reg == IDLE);

endmodule
